control_fsm_param: RTL and testbench

//  Parametrised multi-cycle control unit for the accumulator CPU datapath. Fetches via a
//  mem_req/mem_ready handshake instead of fixed wait states, decodes opcode plus register

---
 rtl/cpu_ctrl_pkg.sv | 64 ++++++
 rtl/ctrl_mem_timer.sv | 27 ++
 rtl/control_fsm_param.sv | 229 ++++++++++++++++++++++
 tb/tb_control_fsm_param.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the accumulator CPU control unit: FSM states,
// opcodes, register-file index map and ALU operation codes.
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_NOP,
    S_MOVACR,
    S_MOVRAC,
    S_MOVACAR,
    S_INCAC,
    S_INCR,
    S_ALU1,
    S_ALU2,
    S_LOADAC,
    S_STAC,
    S_LDIM_INC,
    S_LDIM_RD,
    S_JINC,
    S_JRD,
    S_SKIP,
    S_HALT,
    S_ERROR
  } state_t;

  localparam logic [5:0] OP_NOP     = 6'd0;
  localparam logic [5:0] OP_LOADAC  = 6'd1;
  localparam logic [5:0] OP_STAC    = 6'd2;
  localparam logic [5:0] OP_MOVACR  = 6'd3;
  localparam logic [5:0] OP_MOVRAC  = 6'd4;
  localparam logic [5:0] OP_MOVACAR = 6'd5;
  localparam logic [5:0] OP_ADD     = 6'd6;
  localparam logic [5:0] OP_SUB     = 6'd7;
  localparam logic [5:0] OP_SHL     = 6'd8;
  localparam logic [5:0] OP_SHR     = 6'd9;
  localparam logic [5:0] OP_INCR    = 6'd10;
  localparam logic [5:0] OP_INCAC   = 6'd11;
  localparam logic [5:0] OP_LOADIM  = 6'd12;
  localparam logic [5:0] OP_JUMP    = 6'd13;
  localparam logic [5:0] OP_JZ      = 6'd14;
  localparam logic [5:0] OP_JNZ     = 6'd15;
  localparam logic [5:0] OP_END     = 6'd63;

  // Bus/register index map; general registers start at REG_R0.
  localparam int REG_MEM = 0;
  localparam int REG_PC  = 1;
  localparam int REG_AR  = 2;
  localparam int REG_IR  = 3;
  localparam int REG_AC  = 4;
  localparam int REG_R0  = 5;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_SHL  = 3'd3;
  localparam logic [2:0] ALU_SHR  = 3'd4;

  function automatic int num_reg(input int num_gpr);
    return REG_R0 + num_gpr;
  endfunction

endpackage

// File: rtl/ctrl_mem_timer.sv
// Wait-cycle counter for one memory access. expire is high in the cycle
// whose missing mem_ready would bring the count up to MAX_WAIT.
module ctrl_mem_timer #(
  parameter int MAX_WAIT = 15,
  localparam int CNT_W = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count wait cycles; clear has priority so every access starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= cnt_q + CNT_W'(1);
  end

  assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/control_fsm_param.sv
// Multi-cycle control unit for the accumulator CPU datapath.
// Memory handshake: mem_req stays high for the whole time the FSM sits in a
// memory state; an access completes in the cycle where mem_req and
// mem_ready are both high. mem_ready while mem_req is low has no effect.
// state_dbg exposes the current FSM state for observation.
module control_fsm_param
  import cpu_ctrl_pkg::*;
#(
  parameter int INSTR_W     = 16,
  parameter int NUM_GPR     = 6,
  parameter int MEM_TIMEOUT = 15,
  localparam int NUM_REG    = num_reg(NUM_GPR),
  localparam int SEL_W      = $clog2(NUM_REG)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               z,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_addr_sel,
  output logic [SEL_W-1:0]   read_sel,
  output logic [NUM_REG-1:0] write_en,
  output logic [NUM_REG-1:0] inc_en,
  output logic               ac_from_alu,
  output logic [2:0]         alu_op,
  output logic               end_process,
  output logic               error,
  output state_t             state_dbg
);

  state_t      state_q, state_d;
  logic [3:0]  rs_q;
  logic        take_q;
  logic [2:0]  alu_q;
  logic        in_mem;
  logic        tmo;

  logic [5:0]  opcode;
  logic [3:0]  rs;
  logic        rs_bad;
  logic        take_d;
  logic [2:0]  alu_d;
  logic        unused_instr_bits;

  assign opcode            = instruction[5:0];
  assign rs                = instruction[9:6];
  assign rs_bad            = int'(rs) >= NUM_GPR;
  assign take_d            = (opcode == OP_JUMP) || ((opcode == OP_JZ) && z) ||
                             ((opcode == OP_JNZ) && !z);
  assign unused_instr_bits = ^instruction[INSTR_W-1:10];
  assign state_dbg         = state_q;

  function automatic logic [NUM_REG-1:0] reg_bit(input int idx);
    return NUM_REG'(1) << idx;
  endfunction

  // ALU code for the arithmetic opcodes; anything else passes through.
  always_comb begin
    alu_d = ALU_PASS;
    case (opcode)
      OP_ADD:  alu_d = ALU_ADD;
      OP_SUB:  alu_d = ALU_SUB;
      OP_SHL:  alu_d = ALU_SHL;
      OP_SHR:  alu_d = ALU_SHR;
      default: alu_d = ALU_PASS;
    endcase
  end

  ctrl_mem_timer #(.MAX_WAIT(MEM_TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (!in_mem || mem_ready),
    .en     (in_mem && !mem_ready),
    .expire (tmo)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Capture register field, branch decision and ALU op during DECODE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_q   <= '0;
      take_q <= 1'b0;
      alu_q  <= ALU_PASS;
    end else if (state_q == S_DECODE) begin
      rs_q   <= rs;
      take_q <= take_d;
      alu_q  <= alu_d;
    end
  end

  // Next state and state-decoded control outputs. Every instruction retires
  // by stepping PC past itself before returning to FETCH.
  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    read_sel     = '0;
    write_en     = '0;
    inc_en       = '0;
    ac_from_alu  = 1'b0;
    alu_op       = ALU_PASS;
    end_process  = 1'b0;
    error        = 1'b0;
    in_mem       = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        in_mem  = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) begin
          write_en = reg_bit(REG_IR);
          state_d  = S_DECODE;
        end else if (tmo) state_d = S_ERROR;
      end
      S_DECODE: begin
        case (opcode)
          OP_NOP:     state_d = S_NOP;
          OP_LOADAC:  state_d = S_LOADAC;
          OP_STAC:    state_d = S_STAC;
          OP_MOVACR:  state_d = rs_bad ? S_ERROR : S_MOVACR;
          OP_MOVRAC:  state_d = rs_bad ? S_ERROR : S_MOVRAC;
          OP_MOVACAR: state_d = S_MOVACAR;
          OP_ADD, OP_SUB, OP_SHL, OP_SHR: state_d = S_ALU1;
          OP_INCR:    state_d = rs_bad ? S_ERROR : S_INCR;
          OP_INCAC:   state_d = S_INCAC;
          OP_LOADIM:  state_d = S_LDIM_INC;
          OP_JUMP, OP_JZ, OP_JNZ: state_d = S_JINC;
          OP_END:     state_d = S_HALT;
          default:    state_d = S_ERROR;
        endcase
      end
      S_NOP: begin
        inc_en  = reg_bit(REG_PC);
        state_d = S_FETCH;
      end
      S_MOVACR: begin
        read_sel = SEL_W'(REG_AC);
        write_en = reg_bit(REG_R0 + int'(rs_q));
        inc_en   = reg_bit(REG_PC);
        state_d  = S_FETCH;
      end
      S_MOVRAC: begin
        read_sel = SEL_W'(REG_R0 + int'(rs_q));
        write_en = reg_bit(REG_AC);
        inc_en   = reg_bit(REG_PC);
        state_d  = S_FETCH;
      end
      S_MOVACAR: begin
        read_sel = SEL_W'(REG_AC);
        write_en = reg_bit(REG_AR);
        inc_en   = reg_bit(REG_PC);
        state_d  = S_FETCH;
      end
      S_INCAC: begin
        inc_en  = reg_bit(REG_AC) | reg_bit(REG_PC);
        state_d = S_FETCH;
      end
      S_INCR: begin
        inc_en  = reg_bit(REG_R0 + int'(rs_q)) | reg_bit(REG_PC);
        state_d = S_FETCH;
      end
      S_ALU1: begin
        alu_op  = alu_q;
        state_d = S_ALU2;
      end
      S_ALU2: begin
        alu_op      = alu_q;
        ac_from_alu = 1'b1;
        write_en    = reg_bit(REG_AC);
        inc_en      = reg_bit(REG_PC);
        state_d     = S_FETCH;
      end
      S_LOADAC, S_LDIM_RD: begin
        in_mem       = 1'b1;
        mem_req      = 1'b1;
        mem_addr_sel = (state_q == S_LOADAC);
        if (mem_ready) begin
          write_en = reg_bit(REG_AC);
          inc_en   = reg_bit(REG_PC);
          state_d  = S_FETCH;
        end else if (tmo) state_d = S_ERROR;
      end
      S_STAC: begin
        in_mem       = 1'b1;
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_addr_sel = 1'b1;
        read_sel     = SEL_W'(REG_AC);
        if (mem_ready) begin
          inc_en  = reg_bit(REG_PC);
          state_d = S_FETCH;
        end else if (tmo) state_d = S_ERROR;
      end
      S_LDIM_INC: begin
        inc_en  = reg_bit(REG_PC);
        state_d = S_LDIM_RD;
      end
      S_JINC: begin
        inc_en  = reg_bit(REG_PC);
        state_d = take_q ? S_JRD : S_SKIP;
      end
      S_JRD: begin
        in_mem  = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) begin
          write_en = reg_bit(REG_PC);
          state_d  = S_FETCH;
        end else if (tmo) state_d = S_ERROR;
      end
      S_SKIP: begin
        inc_en  = reg_bit(REG_PC);
        state_d = S_FETCH;
      end
      S_HALT:  end_process = 1'b1;
      S_ERROR: error       = 1'b1;
      default: state_d     = S_ERROR;
    endcase
  end

endmodule

// File: tb/tb_control_fsm_param.sv
// Directed bench for control_fsm_param (NUM_GPR=4, MEM_TIMEOUT=15): a
// cycle-by-cycle vector table for the instruction set plus hand-written
// sequences for reset, traps, timeout and halt.
module tb_control_fsm_param;
  import cpu_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, z, mem_ready;
  logic [15:0] instruction;
  logic        mem_req, mem_we, mem_addr_sel, ac_from_alu, end_process, error;
  logic [3:0]  read_sel;
  logic [8:0]  write_en, inc_en;
  logic [2:0]  alu_op;
  state_t      state_dbg;

  control_fsm_param #(.INSTR_W(16), .NUM_GPR(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .instruction(instruction), .z(z),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .read_sel(read_sel), .write_en(write_en),
    .inc_en(inc_en), .ac_from_alu(ac_from_alu), .alu_op(alu_op),
    .end_process(end_process), .error(error), .state_dbg(state_dbg)
  );

  logic [30:0] act;
  assign act = {mem_req, mem_we, mem_addr_sel, read_sel, write_en, inc_en,
                ac_from_alu, alu_op, end_process, error};

  function automatic logic [30:0] pk(input logic mr, input logic we, input logic as,
                                     input logic [3:0] rs, input logic [8:0] wen,
                                     input logic [8:0] inc, input logic afa,
                                     input logic [2:0] alu, input logic en,
                                     input logic er);
    return {mr, we, as, rs, wen, inc, afa, alu, en, er};
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [30:0] exp_q[$];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  srz;   // {start, mem_ready, z}
    logic [15:0] instr;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic [2:0] srz, input logic [15:0] ins, input logic [30:0] e);
    vec_t v;
    v.srz = srz;
    v.instr = ins;
    vecs.push_back(v);
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; mem_ready = 1'b0; z = 1'b0; instruction = '0;
    #3;
    adv();
    adv();
    rst = 1'b0;
  endtask

  // Start from IDLE, fetch ins with an immediate mem_ready and step into DECODE.
  task automatic launch(input logic [15:0] ins);
    start = 1'b1; instruction = ins; mem_ready = 1'b1;
    adv();            // FETCH
    start = 1'b0;
    adv();            // DECODE
    mem_ready = 1'b0;
    adv();            // first execute cycle
  endtask

  // Count consecutive cycles with mem_req high (bounded).
  task automatic count_req(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!mem_req) break;
      n++;
      adv();
    end
  endtask

  task automatic run_bad(input string nm, input logic [15:0] ins);
    logic [30:0] e_err;
    int bad;
    e_err = pk(1'b0, 1'b0, 1'b0, 4'd0, 9'h0, 9'h0, 1'b0, 3'd0, 1'b0, 1'b1);
    bad = 0;
    do_reset();
    launch(ins);
    for (int k = 0; k < 6; k++) begin
      mem_ready = k[0];
      start = 1'b1;
      @(negedge clk);
      if (act !== e_err) bad++;
      adv();
    end
    check(nm, 64'(bad), 64'd0);
  endtask

  localparam logic [15:0] I_NOP = 16'h0000, I_ADD = 16'h0146, I_JZ = 16'h000E;
  localparam logic [15:0] I_STAC = 16'h0002, I_LOADAC = 16'h0001, I_LDIM = 16'h000C;
  localparam logic [15:0] I_INCR3 = 16'h00CA, I_INCAC = 16'h000B, I_MOVACR3 = 16'h00C3;
  localparam logic [15:0] I_MOVRAC2 = 16'h0084, I_MOVACAR = 16'h0005, I_SHR = 16'h0009;
  localparam logic [15:0] I_JNZ = 16'h000F, I_JUMP = 16'h000D, I_END = 16'h003F;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [30:0] e_z, e_fw, e_fr, e_pci, e_pcl;
    int n, bad;
    e_z   = '0;
    e_fw  = pk(1'b1, 1'b0, 1'b0, 4'd0, 9'h000, 9'h000, 1'b0, 3'd0, 1'b0, 1'b0);
    e_fr  = pk(1'b1, 1'b0, 1'b0, 4'd0, 9'h008, 9'h000, 1'b0, 3'd0, 1'b0, 1'b0);
    e_pci = pk(1'b0, 1'b0, 1'b0, 4'd0, 9'h000, 9'h002, 1'b0, 3'd0, 1'b0, 1'b0);
    e_pcl = pk(1'b1, 1'b0, 1'b0, 4'd0, 9'h002, 9'h000, 1'b0, 3'd0, 1'b0, 1'b0);

    // NOP with three wait cycles; mem_ready in DECODE is ignored
    add(3'b100, I_NOP, e_z);
    add(3'b000, I_NOP, e_fw); add(3'b000, I_NOP, e_fw); add(3'b000, I_NOP, e_fw);
    add(3'b010, I_NOP, e_fr); add(3'b010, I_NOP, e_z);  add(3'b000, I_NOP, e_pci);
    // ADD, rs field ignored
    add(3'b010, I_ADD, e_fr); add(3'b000, I_ADD, e_z);
    add(3'b010, I_ADD, pk(1'b0, 1'b0, 1'b0, 4'd0, 9'h000, 9'h000, 1'b0, 3'd1, 1'b0, 1'b0));
    add(3'b000, I_ADD, pk(1'b0, 1'b0, 1'b0, 4'd0, 9'h010, 9'h002, 1'b1, 3'd1, 1'b0, 1'b0));
    // JZ taken (z=1 in DECODE, z drops afterwards)
    add(3'b011, I_JZ, e_fr); add(3'b001, I_JZ, e_z); add(3'b000, I_JZ, e_pci);
    add(3'b000, I_JZ, e_fw); add(3'b010, I_JZ, e_pcl);
    // JZ not taken (z=0 in DECODE, z rises afterwards)
    add(3'b010, I_JZ, e_fr); add(3'b000, I_JZ, e_z); add(3'b001, I_JZ, e_pci);
    add(3'b011, I_JZ, e_pci);
    // STAC with one wait
    add(3'b010, I_STAC, e_fr); add(3'b000, I_STAC, e_z);
    add(3'b000, I_STAC, pk(1'b1, 1'b1, 1'b1, 4'd4, 9'h000, 9'h000, 1'b0, 3'd0, 1'b0, 1'b0));
    add(3'b010, I_STAC, pk(1'b1, 1'b1, 1'b1, 4'd4, 9'h000, 9'h002, 1'b0, 3'd0, 1'b0, 1'b0));
    // LOADAC
    add(3'b010, I_LOADAC, e_fr); add(3'b000, I_LOADAC, e_z);
    add(3'b010, I_LOADAC, pk(1'b1, 1'b0, 1'b1, 4'd0, 9'h010, 9'h002, 1'b0, 3'd0, 1'b0, 1'b0));
    // LOADIM
    add(3'b010, I_LDIM, e_fr); add(3'b000, I_LDIM, e_z); add(3'b000, I_LDIM, e_pci);
    add(3'b010, I_LDIM, pk(1'b1, 1'b0, 1'b0, 4'd0, 9'h010, 9'h002, 1'b0, 3'd0, 1'b0, 1'b0));
    // INCR R3, INCAC
    add(3'b010, I_INCR3, e_fr); add(3'b000, I_INCR3, e_z);
    add(3'b000, I_INCR3, pk(1'b0, 1'b0, 1'b0, 4'd0, 9'h000, 9'h102, 1'b0, 3'd0, 1'b0, 1'b0));
    add(3'b010, I_INCAC, e_fr); add(3'b000, I_INCAC, e_z);
    add(3'b000, I_INCAC, pk(1'b0, 1'b0, 1'b0, 4'd0, 9'h000, 9'h012, 1'b0, 3'd0, 1'b0, 1'b0));
    // register moves
    add(3'b010, I_MOVACR3, e_fr); add(3'b000, I_MOVACR3, e_z);
    add(3'b000, I_MOVACR3, pk(1'b0, 1'b0, 1'b0, 4'd4, 9'h100, 9'h002, 1'b0, 3'd0, 1'b0, 1'b0));
    add(3'b010, I_MOVRAC2, e_fr); add(3'b000, I_MOVRAC2, e_z);
    add(3'b000, I_MOVRAC2, pk(1'b0, 1'b0, 1'b0, 4'd7, 9'h010, 9'h002, 1'b0, 3'd0, 1'b0, 1'b0));
    add(3'b010, I_MOVACAR, e_fr); add(3'b000, I_MOVACAR, e_z);
    add(3'b000, I_MOVACAR, pk(1'b0, 1'b0, 1'b0, 4'd4, 9'h004, 9'h002, 1'b0, 3'd0, 1'b0, 1'b0));
    // SHR
    add(3'b010, I_SHR, e_fr); add(3'b000, I_SHR, e_z);
    add(3'b000, I_SHR, pk(1'b0, 1'b0, 1'b0, 4'd0, 9'h000, 9'h000, 1'b0, 3'd4, 1'b0, 1'b0));
    add(3'b000, I_SHR, pk(1'b0, 1'b0, 1'b0, 4'd0, 9'h010, 9'h002, 1'b1, 3'd4, 1'b0, 1'b0));
    // JNZ taken, JUMP taken with z=1, JNZ not taken
    add(3'b010, I_JNZ, e_fr); add(3'b000, I_JNZ, e_z); add(3'b000, I_JNZ, e_pci);
    add(3'b010, I_JNZ, e_pcl);
    add(3'b011, I_JUMP, e_fr); add(3'b001, I_JUMP, e_z); add(3'b000, I_JUMP, e_pci);
    add(3'b010, I_JUMP, e_pcl);
    add(3'b011, I_JNZ, e_fr); add(3'b001, I_JNZ, e_z); add(3'b000, I_JNZ, e_pci);
    add(3'b000, I_JNZ, e_pci);
    add(3'b000, I_NOP, e_fw);   // left waiting in FETCH

    // reset state
    rst = 1'b1; start = 1'b0; mem_ready = 1'b0; z = 1'b0; instruction = '0;
    @(negedge clk);
    check("reset_outputs", 64'(act), 64'd0);
    check("reset_state", 64'(state_dbg), 64'(S_IDLE));
    adv();
    rst = 1'b0;

    // table walk
    for (int i = 0; i < vecs.size(); i++) begin
      {start, mem_ready, z} = vecs[i].srz;
      instruction = vecs[i].instr;
      @(negedge clk);
      check($sformatf("vec%0d", i), 64'(act), 64'(exp_q[i]));
      adv();
    end

    // reset in the middle of FETCH drops mem_req immediately
    @(negedge clk);
    check("pre_reset_req", 64'(mem_req), 64'd1);
    adv();
    #2 rst = 1'b1;
    #1 check("async_reset_req", 64'(act), 64'd0);
    adv();
    rst = 1'b0; start = 1'b0; mem_ready = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (act !== '0 || state_dbg != S_IDLE) bad++;
      adv();
    end
    check("idle_hold", 64'(bad), 64'd0);

    // illegal register field and opcode traps
    run_bad("movacr_rs4", 16'h0103);
    run_bad("opcode20", 16'h0014);
    run_bad("incr_rs4", 16'h010A);
    run_bad("movrac_rs5", 16'h0144);

    // LOADAC that never completes
    do_reset();
    launch(I_LOADAC);
    count_req(n);
    check("loadac_wait_cycles", 64'(n), 64'd15);
    check("loadac_timeout_err", 64'(error), 64'd1);

    // FETCH that never completes
    do_reset();
    start = 1'b1;
    adv();
    start = 1'b0;
    count_req(n);
    check("fetch_wait_cycles", 64'(n), 64'd15);
    check("fetch_timeout_err", 64'(error), 64'd1);

    // END halts and stays halted
    do_reset();
    launch(I_END);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      start = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
      z = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (act !== pk(1'b0, 1'b0, 1'b0, 4'd0, 9'h0, 9'h0, 1'b0, 3'd0, 1'b1, 1'b0)) bad++;
      adv();
    end
    check("halt_hold", 64'(bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
